// File: rtl/execute_if.sv
// Interface between the decoder and the execute/writeback stage.
//
// Signals:
//   activateExecute  start strobe from the decoder
//   opcode           3-bit operation
//   dataOpa/dataOpb  32-bit operands
//   addrMor          4-bit destination register index
//   regbank          16 x 32-bit register bank, owned by execute
//   busy             operation in flight
//   done             one-cycle pulse after each writeback
//   flagZ/flagN      zero / negative flags of the last written result
//
// Modports:
//   master  decoder side (drives the operation, reads the bank and status)
//   slave   execute side
interface execute_if;
  logic        activateExecute;
  logic [2:0]  opcode;
  logic [31:0] dataOpa;
  logic [31:0] dataOpb;
  logic [3:0]  addrMor;
  logic [31:0] regbank [0:15];
  logic        busy;
  logic        done;
  logic        flagZ;
  logic        flagN;

  modport master (
    output activateExecute, opcode, dataOpa, dataOpb, addrMor,
    input  regbank, busy, done, flagZ, flagN
  );

  modport slave (
    input  activateExecute, opcode, dataOpa, dataOpb, addrMor,
    output regbank, busy, done, flagZ, flagN
  );
endinterface

// File: rtl/execute.sv
// Execute/writeback stage.
//
// Takes a decoded operation on a start strobe, computes the result and
// writes it into the 16 x 32-bit register bank owned by this block.
// ALU operations complete one edge after the start edge; MUL runs a
// 32-step shift-add sequence and writes on the 32nd edge after start.
//
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low; clears all state
//   bus    execute_if.slave: operation inputs, register bank and status
module execute (
  input  logic     clock,
  input  logic     reset,
  execute_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  opLatch;
  logic [31:0] opaLatch;    // also the shifting multiplicand during MUL
  logic [31:0] opbLatch;    // also the shifting multiplier during MUL
  logic [3:0]  addrLatch;
  logic [31:0] acc;
  logic [4:0]  count;
  logic [31:0] regs [0:15];
  logic        doneReg;
  logic        flagZReg;
  logic        flagNReg;

  logic [31:0] aluResult;
  logic [31:0] mulStep;

  // Single-cycle ALU on the latched operands. MUL has its own path, so
  // its encoding just yields zero here and is never written from this.
  always_comb begin
    aluResult = '0;
    case (opLatch)
      3'b000:  aluResult = opaLatch + opbLatch;
      3'b001:  aluResult = opaLatch - opbLatch;
      3'b010:  aluResult = opaLatch & opbLatch;
      3'b011:  aluResult = opaLatch | opbLatch;
      3'b100:  aluResult = opaLatch ^ opbLatch;
      3'b101:  aluResult = opaLatch << opbLatch[4:0];
      3'b110:  aluResult = opaLatch >> opbLatch[4:0];
      default: aluResult = '0;
    endcase
  end

  // One shift-add step; on the final step this is the product itself.
  assign mulStep = acc + (opbLatch[0] ? opaLatch : 32'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      opLatch   <= '0;
      opaLatch  <= '0;
      opbLatch  <= '0;
      addrLatch <= '0;
      acc       <= '0;
      count     <= '0;
      doneReg   <= 1'b0;
      flagZReg  <= 1'b0;
      flagNReg  <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.activateExecute) begin
            opLatch   <= bus.opcode;
            opaLatch  <= bus.dataOpa;
            opbLatch  <= bus.dataOpb;
            addrLatch <= bus.addrMor;
            acc       <= '0;
            count     <= '0;
            state     <= (bus.opcode == 3'b111) ? MUL : EXEC;
          end
        end
        EXEC: begin
          regs[addrLatch] <= aluResult;
          flagZReg        <= (aluResult == 32'd0);
          flagNReg        <= aluResult[31];
          doneReg         <= 1'b1;
          state           <= IDLE;
        end
        MUL: begin
          acc      <= mulStep;
          opaLatch <= opaLatch << 1;
          opbLatch <= opbLatch >> 1;
          count    <= count + 5'd1;
          if (count == 5'd31) begin
            regs[addrLatch] <= mulStep;
            flagZReg        <= (mulStep == 32'd0);
            flagNReg        <= mulStep[31];
            doneReg         <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state == EXEC) || (state == MUL);
  assign bus.done  = doneReg;
  assign bus.flagZ = flagZReg;
  assign bus.flagN = flagNReg;

  // The bank is exported straight from the storage flops.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bank
      assign bus.regbank[gi] = regs[gi];
    end
  endgenerate

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_execute;

  logic clock;
  logic reset;

  execute_if bus ();

  execute dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] model [0:15];
  logic        modelZ;
  logic        modelN;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return 32'(64'(a) * 64'(b));
    endcase
  endfunction

  task automatic checkBank(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_r%0d", tag, i), bus.regbank[i], model[i]);
    check({tag, "_flagZ"}, {31'd0, bus.flagZ}, {31'd0, modelZ});
    check({tag, "_flagN"}, {31'd0, bus.flagN}, {31'd0, modelN});
  endtask

  // Drives a start at the current time and returns #1 after the start edge,
  // with the operand inputs scrambled so only latched copies can matter.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] addr);
    bus.opcode          = op;
    bus.dataOpa         = a;
    bus.dataOpb         = b;
    bus.addrMor         = addr;
    bus.activateExecute = 1'b1;
    @(posedge clock);
    #1;
    bus.activateExecute = 1'b0;
    bus.opcode          = 3'($urandom);
    bus.dataOpa         = $urandom;
    bus.dataOpb         = $urandom;
    bus.addrMor         = 4'($urandom);
  endtask

  // Called #1 after the start edge: waits for done, checks latency and state.
  task automatic finishOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] addr);
    int cycles;
    int busyCycles;
    logic [31:0] r;
    cycles     = 0;
    busyCycles = 0;
    check({tag, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
    while (!bus.done && cycles < 40) begin
      if (bus.busy) busyCycles++;
      @(posedge clock);
      #1;
      cycles++;
    end
    check({tag, "_latency"}, cycles, (op == 3'd7) ? 32'd32 : 32'd1);
    check({tag, "_busy_cycles"}, busyCycles, (op == 3'd7) ? 32'd32 : 32'd1);
    check({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    r           = refResult(op, a, b);
    model[addr] = r;
    modelZ      = (r == 32'd0);
    modelN      = r[31];
    check({tag, "_result"}, bus.regbank[addr], r);
    checkBank(tag);
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] addr);
    @(negedge clock);
    issue(op, a, b, addr);
    finishOp(tag, op, a, b, addr);
    @(posedge clock);
    #1;
    check({tag, "_done_fall"}, {31'd0, bus.done}, 32'd0);
    $display("op %s opc=%0d a=%h b=%h r%0d=%h", tag, op, a, b, addr, bus.regbank[addr]);
  endtask

  initial begin
    int doneCount;
    int doneAt;
    logic [31:0] r;

    bus.activateExecute = 1'b0;
    bus.opcode          = '0;
    bus.dataOpa         = '0;
    bus.dataOpb         = '0;
    bus.addrMor         = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    modelZ = 1'b0;
    modelN = 1'b0;

    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkBank("reset");
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);

    // Directed cases
    runOp("add", 3'd0, 32'd5, 32'd7, 4'd3);
    runOp("sub", 3'd1, 32'd2, 32'd5, 4'd4);
    runOp("xor", 3'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'd4);
    runOp("mul_neg", 3'd7, 32'hFFFFFFFF, 32'd3, 4'd7);
    runOp("mul_dec", 3'd7, 32'd1234, 32'd5678, 4'd8);
    runOp("shl33", 3'd5, 32'd1, 32'd33, 4'd10);
    runOp("shr31", 3'd6, 32'h80000000, 32'd31, 4'd11);
    runOp("and", 3'd2, 32'hF0F0FF00, 32'h0FF0F0F0, 4'd0);
    runOp("or", 3'd3, 32'h12340000, 32'h00005678, 4'd15);

    // Start accepted in the done cycle
    @(negedge clock);
    issue(3'd0, 32'd100, 32'd23, 4'd12);
    finishOp("b2b_first", 3'd0, 32'd100, 32'd23, 4'd12);
    issue(3'd1, 32'd10, 32'd3, 4'd13);
    finishOp("b2b_second", 3'd1, 32'd10, 32'd3, 4'd13);
    $display("op b2b r12=%h r13=%h", bus.regbank[12], bus.regbank[13]);

    // Starts while MUL is busy are ignored
    @(negedge clock);
    issue(3'd7, 32'd77, 32'd1001, 4'd7);
    doneCount = 0;
    doneAt    = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c >= 5 && c <= 10) begin
        bus.activateExecute = 1'b1;
        bus.opcode          = 3'd0;
        bus.dataOpa         = 32'd9;
        bus.dataOpb         = 32'd9;
        bus.addrMor         = 4'd7;
      end else begin
        bus.activateExecute = 1'b0;
      end
      @(posedge clock);
      #1;
      if (bus.done) begin
        doneCount++;
        doneAt = c;
      end
    end
    bus.activateExecute = 1'b0;
    r = refResult(3'd7, 32'd77, 32'd1001);
    model[7] = r;
    modelZ   = (r == 32'd0);
    modelN   = r[31];
    check("ignore_done_count", doneCount, 32'd1);
    check("ignore_done_at", doneAt, 32'd32);
    check("ignore_busy", {31'd0, bus.busy}, 32'd0);
    checkBank("ignore");
    $display("op ignore r7=%h dones=%0d", bus.regbank[7], doneCount);

    // Reset mid-MUL
    runOp("preload", 3'd0, 32'h55, 32'd0, 4'd9);
    @(negedge clock);
    issue(3'd7, 32'd123, 32'd456, 4'd9);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    modelZ = 1'b0;
    modelN = 1'b0;
    checkBank("midreset");
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    runOp("post_reset", 3'd0, 32'd1, 32'd1, 4'd9);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      runOp($sformatf("rnd%0d", n), op, a, b, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/execute.md
Name: execute

Overview:
Execute/writeback stage directly downstream of the instruction decoder. It accepts the registered decoded operation (opcode, operand A, operand B and destination register index) and computes the result. Single-cycle ALU operations use a 2-state path; MUL uses a 32-cycle iterative shift-add unit. It writes the result into the 16x32 register bank it owns, and exports that bank to the decoder for operand reads.

Parameters:
None. Widths are fixed by the ISA: 32-bit data, 16 registers, 3-bit opcode.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; clears all state
activateExecute  input  1  start strobe; sampled on rising edge, honoured only in IDLE
opcode  input  3  operation from decoder
dataOpa  input  32  operand A from decoder
dataOpb  input  32  operand B from decoder (register value or sign-extended immediate)
addrMor  input  4  destination register index
regbank  output  32 x [0:15]  register bank contents, driven straight from the storage flops
busy  output  1  high while state is EXEC or MUL (combinational from state)
done  output  1  one-cycle pulse, registered, high in the cycle after a writeback edge
flagZ  output  1  last written result == 0
flagN  output  1  bit 31 of last written result

Behaviour:
- Reset (async, active-low): state=IDLE; all 16 registers=0; done=0; flagZ=0; flagN=0; internal latches and counter=0. An operation in flight is aborted and no write occurs.
- Opcode map (results are 32-bit, wrap modulo 2^32, no carry/overflow flags):
  - 000 ADD: A+B
  - 001 SUB: A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: A << B[4:0]
  - 110 SHR (logical): A >> B[4:0]
  - 111 MUL: low 32 bits of A*B
- Shift amount uses only B[4:0]; upper bits of B are ignored (B=33 shifts by 1).
- States: IDLE, EXEC, MUL.
- IDLE:
  - If activateExecute=1 at edge k, latch opcode, A, B and addrMor.
  - Go to MUL if opcode=111, else go to EXEC.
  - MUL entry also clears the accumulator and cycle counter.
- EXEC:
  - At edge k+1, write the ALU result to regbank[addr] and update flagZ/flagN from it.
  - Set done<=1 and return to IDLE.
- MUL:
  - Each edge performs one step: if multiplier[0], acc+=multiplicand; then multiplicand<<=1, multiplier>>=1, count++.
  - At the edge where count==31, the step result is written to regbank[addr]; flags are updated and done<=1; state goes to IDLE.
  - The write therefore lands at edge k+32.
- done: high for exactly one cycle after each writeback edge, otherwise 0.
- Latency:
  - ALU: start edge k -> register updated at edge k+1; earliest next start at edge k+2 (the done cycle).
  - MUL: start edge k -> write at edge k+32.
- activateExecute while busy is ignored: no latch, no queueing, no effect on the in-flight operation.
- activateExecute in the done cycle (state=IDLE) is accepted normally.
- Operand inputs may change freely after the start edge; only the latched copies are used.
- All 16 registers are writable, including r0.
- Only the destination register changes on a writeback; every other register holds.
- Flags change only on a writeback edge and hold otherwise.
- Reset deasserted mid-stream: block resumes in IDLE; the first start after reset behaves normally.

Test Plan:
- Reset, then start ADD with A=5, B=7, addr=3 at edge k -> regbank[3]=12 after edge k+1; done=1 for one cycle; flagZ=0, flagN=0; busy=1 only between edges k and k+1.
- SUB with A=2, B=5, addr=4 -> regbank[4]=0xFFFFFFFD, flagN=1, flagZ=0. Then XOR with A=B=0xA5A5A5A5, addr=4 -> regbank[4]=0, flagZ=1, flagN=0.
- MUL with A=0xFFFFFFFF, B=3, addr=7 at edge k -> busy=1 for 32 cycles; regbank[7]=0xFFFFFFFD at edge k+32; done pulses once. Also check MUL 1234*5678 -> 7006652.
- Start MUL, then assert activateExecute with ADD (addr=7) on cycles 5-10 -> ADD ignored; only the MUL result is written; one done pulse total.
- SHL with A=1, B=33 -> result 2. SHR with A=0x80000000, B=31 -> result 1; no sign extension.
- Pull reset low at cycle 15 of a MUL targeting r9 preloaded with 0x55 -> all registers=0, busy=0, done=0. After release, ADD 1+1 into r9 -> regbank[9]=2.
